regfile_clear_ctrl: RTL and testbench

//  Sequencer and write-port arbiter for the 32x32 CPU register file. On reset or on request it

---
 rtl/regfile_clear_ctrl.sv | 113 +++++++++++
 tb/tb_regfile_clear_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_clear_ctrl.sv
// Register-file clear sequencer and write-port arbiter: sweeps FIRST_ADDR..last writing
// CLEAR_VALUE while stalling the CPU, otherwise passes the CPU write port straight through.
module regfile_clear_ctrl #(
    parameter int                        ADDR_WIDTH     = 5,
    parameter int                        DATA_WIDTH     = 32,
    parameter int                        FIRST_ADDR     = 1,
    parameter logic [DATA_WIDTH-1:0]     CLEAR_VALUE    = '0,
    parameter int                        CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear_req,
    input  logic                  cpu_reg_write,
    input  logic [ADDR_WIDTH-1:0] cpu_write_addr,
    input  logic [DATA_WIDTH-1:0] cpu_write_data,
    output logic                  rf_reg_write,
    output logic [ADDR_WIDTH-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic                  cpu_stall,
    output logic                  busy,
    output logic                  done
);

    // state | meaning
    // IDLE  | CPU owns the write port
    // CLEAR | one clear write per cycle, CPU stalled
    // DONE  | single-cycle completion pulse, CPU owns the port again
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] FIRST = ADDR_WIDTH'(FIRST_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST  = '1;
    localparam logic                  STALL_IN_RESET = (CLEAR_ON_RESET != 0);

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= STALL_IN_RESET ? S_CLEAR : S_IDLE;
            cnt   <= FIRST;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (clear_req) begin
                    state_next = S_CLEAR;
                    cnt_next   = FIRST;
                end
            end
            S_CLEAR: begin
                // Counter holds at LAST so it can never wrap past the top address.
                if (cnt == LAST) begin
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt + ADDR_WIDTH'(1);
                end
            end
            S_DONE: begin
                if (clear_req) begin
                    state_next = S_CLEAR;
                    cnt_next   = FIRST;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = FIRST;
            end
        endcase
    end

    always_comb begin
        rf_reg_write  = cpu_reg_write;
        rf_write_addr = cpu_write_addr;
        rf_write_data = cpu_write_data;
        cpu_stall     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            S_CLEAR: begin
                rf_reg_write  = 1'b1;
                rf_write_addr = cnt;
                rf_write_data = CLEAR_VALUE;
                cpu_stall     = 1'b1;
                busy          = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
        // Reset gates the port immediately so an aborted sweep stops writing at once.
        if (!reset_n) begin
            rf_reg_write  = 1'b0;
            rf_write_addr = '0;
            rf_write_data = '0;
            done          = 1'b0;
            cpu_stall     = STALL_IN_RESET;
            busy          = STALL_IN_RESET;
        end
    end

endmodule

// File: tb/tb_regfile_clear_ctrl.sv
// Directed bench for regfile_clear_ctrl: default instance plus a CLEAR_ON_RESET=0,
// FIRST_ADDR=31 instance, with a behavioural register file on the default instance.
module tb_regfile_clear_ctrl;

    logic        clk = 1'b0;
    logic        reset_n, reset_n2;
    logic        clear_req, clear_req2;
    logic        cpu_reg_write, cpu_reg_write2;
    logic [4:0]  cpu_write_addr, cpu_write_addr2;
    logic [31:0] cpu_write_data, cpu_write_data2;
    logic        rf_reg_write, rf_reg_write2;
    logic [4:0]  rf_write_addr, rf_write_addr2;
    logic [31:0] rf_write_data, rf_write_data2;
    logic        cpu_stall, cpu_stall2, busy, busy2, done, done2;

    logic        mem_init;
    logic [31:0] rf_mem [32];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_clear_ctrl dut (
        .clk(clk), .reset_n(reset_n), .clear_req(clear_req),
        .cpu_reg_write(cpu_reg_write), .cpu_write_addr(cpu_write_addr),
        .cpu_write_data(cpu_write_data), .rf_reg_write(rf_reg_write),
        .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .cpu_stall(cpu_stall), .busy(busy), .done(done)
    );

    regfile_clear_ctrl #(.FIRST_ADDR(31), .CLEAR_ON_RESET(0)) dut2 (
        .clk(clk), .reset_n(reset_n2), .clear_req(clear_req2),
        .cpu_reg_write(cpu_reg_write2), .cpu_write_addr(cpu_write_addr2),
        .cpu_write_data(cpu_write_data2), .rf_reg_write(rf_reg_write2),
        .rf_write_addr(rf_write_addr2), .rf_write_data(rf_write_data2),
        .cpu_stall(cpu_stall2), .busy(busy2), .done(done2)
    );

    // Register file model; $zero is hardwired
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'hdead_beef;
        end else if (rf_reg_write && rf_write_addr != 5'd0) begin
            rf_mem[rf_write_addr] <= rf_write_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks CLEAR writes first..31, one per cycle; returns positioned in DONE.
    task automatic sweep(input string tag, input int first);
        for (int a = first; a < 32; a++) begin
            chk({tag, "_busy"},  32'(busy), 32'd1);
            chk({tag, "_stall"}, 32'(cpu_stall), 32'd1);
            chk({tag, "_we"},    32'(rf_reg_write), 32'd1);
            chk({tag, "_addr"},  32'(rf_write_addr), 32'(a));
            chk({tag, "_data"},  rf_write_data, 32'h0);
            chk({tag, "_done"},  32'(done), 32'd0);
            step();
        end
    endtask

    task automatic chk_done(input string tag);
        chk({tag, "_done_pulse"}, 32'(done), 32'd1);
        chk({tag, "_done_busy"},  32'(busy), 32'd0);
        chk({tag, "_done_stall"}, 32'(cpu_stall), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; reset_n2 = 1'b0;
        clear_req = 1'b0; clear_req2 = 1'b0;
        cpu_reg_write = 1'b0; cpu_write_addr = '0; cpu_write_data = '0;
        cpu_reg_write2 = 1'b0; cpu_write_addr2 = '0; cpu_write_data2 = '0;
        mem_init = 1'b1;
        step();
        mem_init = 1'b0;
        #1;
        // reset-time outputs
        chk("rst_we",     32'(rf_reg_write), 32'd0);
        chk("rst_addr",   32'(rf_write_addr), 32'd0);
        chk("rst_data",   rf_write_data, 32'd0);
        chk("rst_busy",   32'(busy), 32'd1);
        chk("rst_stall",  32'(cpu_stall), 32'd1);
        chk("rst_done",   32'(done), 32'd0);
        chk("rst2_busy",  32'(busy2), 32'd0);
        chk("rst2_stall", 32'(cpu_stall2), 32'd0);
        chk("rst2_we",    32'(rf_reg_write2), 32'd0);

        // 1: sweep after reset release
        reset_n = 1'b1; reset_n2 = 1'b1;
        #1;
        sweep("t1", 1);
        chk_done("t1");
        step();
        chk("t1_idle_done", 32'(done), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        for (int r = 1; r < 32; r++) chk($sformatf("t1_reg%0d", r), rf_mem[r], 32'h0);

        // 2: pass-through
        cpu_reg_write = 1'b1; cpu_write_addr = 5'd8; cpu_write_data = 32'h65;
        #1;
        chk("t2_we",    32'(rf_reg_write), 32'd1);
        chk("t2_addr",  32'(rf_write_addr), 32'd8);
        chk("t2_data",  rf_write_data, 32'h65);
        chk("t2_stall", 32'(cpu_stall), 32'd0);
        step();
        chk("t2_reg8", rf_mem[8], 32'h65);
        cpu_write_addr = 5'd9;  cpu_write_data = 32'h0a; step();
        cpu_write_addr = 5'd10; cpu_write_data = 32'h65; step();
        cpu_write_addr = 5'd11; cpu_write_data = 32'h2a; step();
        chk("t2_reg9",  rf_mem[9],  32'h0a);
        chk("t2_reg10", rf_mem[10], 32'h65);
        chk("t2_reg11", rf_mem[11], 32'h2a);
        cpu_reg_write = 1'b0;
        #1;
        chk("t2_we_off", 32'(rf_reg_write), 32'd0);

        // 3: clear request, CPU write in request cycle passes, later ones dropped
        clear_req = 1'b1; cpu_reg_write = 1'b1; cpu_write_addr = 5'd12; cpu_write_data = 32'h77;
        #1;
        chk("t3_req_addr",  32'(rf_write_addr), 32'd12);
        chk("t3_req_stall", 32'(cpu_stall), 32'd0);
        step();
        chk("t3_reg12_pre", rf_mem[12], 32'h77);
        clear_req = 1'b0; cpu_write_addr = 5'd5; cpu_write_data = 32'hffff_ffff;
        #1;
        sweep("t3", 1);
        chk_done("t3");
        cpu_reg_write = 1'b0;
        step();
        for (int r = 5; r < 13; r++) chk($sformatf("t3_reg%0d", r), rf_mem[r], 32'h0);

        // 4: clear_req held across CLEAR and DONE
        clear_req = 1'b1;
        step();
        sweep("t4a", 1);
        chk_done("t4");
        step();
        clear_req = 1'b0;
        #1;
        sweep("t4b", 1);
        chk_done("t4b");
        step();
        chk("t4_idle_busy", 32'(busy), 32'd0);

        // 5: reset mid-sweep at address 15
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        #1;
        for (int a = 1; a < 15; a++) step();
        chk("t5_at15", 32'(rf_write_addr), 32'd15);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_we",   32'(rf_reg_write), 32'd0);
        chk("t5_rst_addr", 32'(rf_write_addr), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd1);
        step();
        reset_n = 1'b1;
        #1;
        sweep("t5", 1);
        chk_done("t5");
        step();
        chk("t5_idle_done", 32'(done), 32'd0);

        // 6: CLEAR_ON_RESET=0, FIRST_ADDR=31 instance
        cpu_reg_write2 = 1'b1; cpu_write_addr2 = 5'd3; cpu_write_data2 = 32'h1234;
        #1;
        chk("t6_idle_stall", 32'(cpu_stall2), 32'd0);
        chk("t6_idle_addr",  32'(rf_write_addr2), 32'd3);
        chk("t6_idle_data",  rf_write_data2, 32'h1234);
        cpu_reg_write2 = 1'b0;
        clear_req2 = 1'b1;
        step();
        clear_req2 = 1'b0;
        #1;
        chk("t6_clr_busy", 32'(busy2), 32'd1);
        chk("t6_clr_we",   32'(rf_reg_write2), 32'd1);
        chk("t6_clr_addr", 32'(rf_write_addr2), 32'd31);
        chk("t6_clr_data", rf_write_data2, 32'h0);
        step();
        chk("t6_done",      32'(done2), 32'd1);
        chk("t6_done_busy", 32'(busy2), 32'd0);
        chk("t6_done_we",   32'(rf_reg_write2), 32'd0);
        step();
        chk("t6_idle_done",  32'(done2), 32'd0);
        chk("t6_idle_busy2", 32'(busy2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
